// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: pin conditioning, frame deserialiser, E0/F0
// prefix parser and a first-word-fall-through event FIFO with valid/ready.
module ps2_key_event_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clock,
  input  logic                          ps2_data,
  input  logic                          ev_ready,
  input  logic                          clear_err,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_break,
  output logic                          ev_extended,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [7:0]                    err_count
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] flt_cnt;
  logic          bit_edge;

  state_t        state;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit, stop_ok, accept_now, reject_now;

  logic          acc_vld;
  logic [7:0]    acc_byte;
  logic          pend_ext, pend_brk;
  logic          is_prefix, is_resp, emit;

  ev_t           mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push_ok, drop;

  // Two-flop synchronisers; idle level of both pins is high
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clock; clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;  dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: level follows only after FILTER_LEN equal samples
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_s2 == filt_clk) begin
      flt_cnt  <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      filt_clk <= clk_s2;
      flt_cnt  <= '0;
    end else begin
      flt_cnt  <= flt_cnt + 1'b1;
    end
  end

  // Bit edge fires in the cycle the filtered clock is about to fall
  always_comb begin
    bit_edge    = filt_clk & ~clk_s2 & (flt_cnt == FW'(FILTER_LEN - 1));
    timeout_hit = (state != IDLE) & ~bit_edge & (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    stop_ok     = dat_s2 & (^shift ^ par_bit);
    accept_now  = (state == STOP) & bit_edge & stop_ok;
    reject_now  = ((state == STOP) & bit_edge & ~stop_ok) | timeout_hit;
  end

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop; plus timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (state == IDLE || bit_edge) to_cnt <= '0;
      else                           to_cnt <= to_cnt + 1'b1;
      if (timeout_hit) begin
        state <= IDLE;
      end else if (bit_edge) begin
        case (state)
          IDLE:   if (!dat_s2) begin state <= DATA; bit_idx <= '0; end
          DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
          PARITY: begin par_bit <= dat_s2; state <= STOP; end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Byte classification for the parser
  always_comb begin
    is_prefix = (acc_byte == 8'hE0) | (acc_byte == 8'hF0);
    case (acc_byte)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_resp = 1'b1;
      default:                                         is_resp = 1'b0;
    endcase
    emit    = acc_vld & ~is_prefix & ~is_resp;
    full    = (count == CW'(FIFO_DEPTH));
    pop     = ev_valid & ev_ready;
    push_ok = emit & (~full | pop);
    drop    = emit & full & ~pop;
  end

  // Accepted-byte register, error accounting and prefix tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_vld   <= 1'b0;
      acc_byte  <= '0;
      frame_err <= 1'b0;
      err_count <= '0;
      pend_ext  <= 1'b0;
      pend_brk  <= 1'b0;
    end else begin
      acc_vld   <= accept_now;
      frame_err <= reject_now;
      if (accept_now) acc_byte <= shift;
      if (reject_now)
        err_count <= clear_err ? 8'd1 :
                     (err_count == 8'hFF) ? err_count : err_count + 1'b1;
      else if (clear_err)
        err_count <= '0;
      // frame_err and acc_vld are never high in the same cycle
      if (frame_err) begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end else if (acc_vld) begin
        if (acc_byte == 8'hE0)      pend_ext <= 1'b1;
        else if (acc_byte == 8'hF0) pend_brk <= 1'b1;
        else begin
          pend_ext <= 1'b0;
          pend_brk <= 1'b0;
        end
      end
    end
  end

  // FIFO storage, no reset needed since outputs are gated by ev_valid
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{ext: pend_ext, brk: pend_brk, code: acc_byte};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
    end
  end

  ev_t head;
  assign head        = mem[rd_ptr];
  assign ev_valid    = (count != '0);
  assign ev_count    = count;
  assign ev_code     = ev_valid ? head.code : 8'h00;
  assign ev_break    = ev_valid & head.brk;
  assign ev_extended = ev_valid & head.ext;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: table of frames plus corner sequences.
module tb_ps2_key_event_rx;
  localparam int FL   = 8;
  localparam int TO   = 500;
  localparam int D    = 4;
  localparam int HALF = 20;

  logic       clk = 0;
  logic       reset, ps2_clock, ps2_data, ev_ready, clear_err;
  logic       ev_valid, ev_break, ev_extended, overflow, frame_err;
  logic [7:0] ev_code, err_count;
  logic [$clog2(D):0] ev_count;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;

  ps2_key_event_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .ev_ready(ev_ready), .clear_err(clear_err), .ev_valid(ev_valid),
    .ev_code(ev_code), .ev_break(ev_break), .ev_extended(ev_extended),
    .ev_count(ev_count), .overflow(overflow), .frame_err(frame_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Count cycles in which frame_err is high
  always @(negedge clk) if (!reset && frame_err) fe_cnt++;

  typedef struct {
    logic [7:0] b;
    bit         badp;
    bit         pop;
    int         cnt;
    logic [7:0] code;
    bit         brk;
    bit         ext;
    int         err;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clock = 1'b0;
    wait_cyc(HALF);
    ps2_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit badp);
    logic par;
    par = ~(^b) ^ badp;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
    wait_cyc(20);
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    wait_cyc(1);
    ev_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] codes [5];
    logic [7:0] b1c;
    int e0;

    tbl[0]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0};
    tbl[1]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0};
    tbl[2]  = '{8'h75, 0, 1, 1, 8'h75, 1, 1, 0};
    tbl[3]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0};
    tbl[4]  = '{8'h1C, 0, 1, 1, 8'h1C, 1, 0, 0};
    tbl[5]  = '{8'h1C, 1, 0, 0, 8'h00, 0, 0, 1};
    tbl[6]  = '{8'h29, 0, 1, 1, 8'h29, 0, 0, 1};
    tbl[7]  = '{8'hFA, 0, 0, 0, 8'h00, 0, 0, 1};
    tbl[8]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 1};
    tbl[9]  = '{8'h1C, 1, 0, 0, 8'h00, 0, 0, 2};
    tbl[10] = '{8'h6B, 0, 1, 1, 8'h6B, 0, 0, 2};
    tbl[11] = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 2};
    tbl[12] = '{8'hAA, 0, 0, 0, 8'h00, 0, 0, 2};
    tbl[13] = '{8'h12, 0, 1, 1, 8'h12, 0, 0, 2};
    tbl[14] = '{8'hE1, 0, 1, 1, 8'hE1, 0, 0, 2};
    tbl[15] = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 2};
    tbl[16] = '{8'h70, 0, 1, 1, 8'h70, 0, 1, 2};
    codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h24;
    codes[3] = 8'h2D; codes[4] = 8'h2C;

    reset = 1; ps2_clock = 1; ps2_data = 1; ev_ready = 0; clear_err = 0;
    wait_cyc(4);
    reset = 0;
    wait_cyc(2);
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", ev_count, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_errcnt", err_count, 0);

    // Exact latency from STOP bit edge to ev_valid, with ev_ready held high
    ev_ready = 1;
    b1c = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b1c[i]);
    send_bit(1'b0);
    ps2_data = 1'b1;
    wait_cyc(HALF);
    ps2_clock = 1'b0;
    repeat (FL + 2) @(posedge clk);
    @(negedge clk);
    chk("lat_valid_early", ev_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_valid", ev_valid, 1);
    chk("lat_code", ev_code, 8'h1C);
    chk("lat_brk", ev_break, 0);
    chk("lat_ext", ev_extended, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_valid_drop", ev_valid, 0);
    wait_cyc(HALF);
    ps2_clock = 1'b1;
    ev_ready = 0;
    wait_cyc(20);

    // Table of frames: prefixes, rejects, responses, ordinary codes
    for (int i = 0; i < 17; i++) begin
      send_frame(tbl[i].b, tbl[i].badp);
      chk($sformatf("t%0d_count", i), ev_count, tbl[i].cnt);
      chk($sformatf("t%0d_code", i), ev_code, tbl[i].code);
      chk($sformatf("t%0d_brk", i), ev_break, tbl[i].brk);
      chk($sformatf("t%0d_ext", i), ev_extended, tbl[i].ext);
      chk($sformatf("t%0d_errcnt", i), err_count, tbl[i].err);
      chk($sformatf("t%0d_ferr_pulses", i), fe_cnt, tbl[i].err);
      if (tbl[i].pop) begin
        pop_one();
        chk($sformatf("t%0d_popped", i), ev_valid, 0);
      end
    end

    // Overflow: one more make code than the FIFO holds
    for (int i = 0; i < D + 1; i++) send_frame(codes[i], 0);
    chk("ovf_count", ev_count, D);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < D; i++) begin
      chk($sformatf("drain%0d_valid", i), ev_valid, 1);
      chk($sformatf("drain%0d_code", i), ev_code, codes[i]);
      pop_one();
    end
    chk("drain_empty", ev_valid, 0);
    chk("ovf_sticky", overflow, 1);
    clear_err = 1;
    wait_cyc(1);
    clear_err = 0;
    chk("clr_ovf", overflow, 0);
    chk("clr_errcnt", err_count, 0);

    // Timeout: clock stops after four data bits
    e0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_cyc(TO + 50);
    chk("to_pulse", fe_cnt - e0, 1);
    chk("to_errcnt", err_count, 1);
    chk("to_novalid", ev_valid, 0);
    send_frame(8'h16, 0);
    chk("to_next_valid", ev_valid, 1);
    chk("to_next_code", ev_code, 8'h16);
    chk("to_next_flags", {ev_break, ev_extended}, 0);

    // Glitch of FILTER_LEN-1 samples with data low must not start a frame
    e0 = fe_cnt;
    ps2_data = 1'b0;
    ps2_clock = 1'b0;
    wait_cyc(FL - 1);
    ps2_clock = 1'b1;
    wait_cyc(TO + 50);
    ps2_data = 1'b1;
    chk("glitch_noerr", fe_cnt - e0, 0);
    chk("glitch_errcnt", err_count, 1);
    chk("glitch_count", ev_count, 1);

    // Reset mid-frame with an event queued and a nonzero error count
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    reset = 1;
    wait_cyc(1);
    reset = 0;
    wait_cyc(1);
    chk("mrst_valid", ev_valid, 0);
    chk("mrst_count", ev_count, 0);
    chk("mrst_errcnt", err_count, 0);
    chk("mrst_code", ev_code, 0);
    wait_cyc(40);
    send_frame(8'h24, 0);
    chk("mrst_next_valid", ev_valid, 1);
    chk("mrst_next_code", ev_code, 8'h24);
    chk("mrst_next_errcnt", err_count, 0);
    pop_one();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
